// File: rtl/acc_alu_pkg.sv
// Shared types for the accumulator ALU unit: opcode and sequencer-state enums.
package acc_alu_pkg;

   localparam int OPC_W   = 4;
   localparam int NUM_OPS = 12;

   typedef enum logic [OPC_W-1:0] {
      OP_LOAD = 4'd0,
      OP_ADD  = 4'd1,
      OP_ADC  = 4'd2,
      OP_SUB  = 4'd3,
      OP_SBC  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_CMP  = 4'd10,
      OP_MUL  = 4'd11
   } op_e;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } seq_state_e;

endpackage

// File: rtl/acc_alu_unit_alu_comb.sv
// Combinational result/carry/zero for all single-cycle ops and CMP, plus
// per-op write enables for A, CY and Z.
module alu_comb
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OPC_W-1:0] op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] r_i,
   input  logic             cy_i,
   output logic [WIDTH-1:0] res_o,
   output logic             cy_o,
   output logic             zero_o,
   output logic             wr_a_o,
   output logic             wr_cy_o,
   output logic             wr_z_o
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;
   logic           cin_s;
   logic           bin_s;

   // Carry-in / borrow-in only apply to the chained variants.
   always_comb begin
      cin_s  = (op_i == OP_ADC) ? cy_i : 1'b0;
      bin_s  = (op_i == OP_SBC) ? cy_i : 1'b0;
      sum_s  = {1'b0, a_i} + {1'b0, r_i} + {{WIDTH{1'b0}}, cin_s};
      diff_s = {1'b0, a_i} - {1'b0, r_i} - {{WIDTH{1'b0}}, bin_s};
   end

   // Opcode decode: result, carry and which state elements are written.
   always_comb begin
      res_o   = a_i;
      cy_o    = cy_i;
      wr_a_o  = 1'b1;
      wr_cy_o = 1'b0;
      wr_z_o  = 1'b1;
      case (op_i)
         OP_LOAD: res_o = r_i;
         OP_ADD, OP_ADC: begin
            res_o   = sum_s[WIDTH-1:0];
            cy_o    = sum_s[WIDTH];
            wr_cy_o = 1'b1;
         end
         OP_SUB, OP_SBC: begin
            res_o   = diff_s[WIDTH-1:0];
            cy_o    = diff_s[WIDTH];
            wr_cy_o = 1'b1;
         end
         OP_AND: res_o = a_i & r_i;
         OP_OR:  res_o = a_i | r_i;
         OP_XOR: res_o = a_i ^ r_i;
         OP_SHL: begin
            res_o   = {a_i[WIDTH-2:0], cy_i};
            cy_o    = a_i[WIDTH-1];
            wr_cy_o = 1'b1;
         end
         OP_SHR: begin
            res_o   = {cy_i, a_i[WIDTH-1:1]};
            cy_o    = a_i[0];
            wr_cy_o = 1'b1;
         end
         OP_CMP: begin
            res_o   = diff_s[WIDTH-1:0];
            cy_o    = diff_s[WIDTH];
            wr_a_o  = 1'b0;
            wr_cy_o = 1'b1;
         end
         default: begin
            // MUL is sequenced by the top; undefined opcodes are no-ops.
            wr_a_o  = 1'b0;
            wr_cy_o = 1'b0;
            wr_z_o  = 1'b0;
         end
      endcase
   end

   assign zero_o = (res_o == {WIDTH{1'b0}});

endmodule

// File: rtl/acc_alu_unit.sv
// Accumulator datapath: A/H/CY/Z registers, start/busy/done handshake and a
// WIDTH-iteration shift-add multiplier leaving the product in {H,A}.
module acc_alu_unit
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] H,
   output logic             CY,
   output logic             Z,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] h_q, h_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic             cy_q, cy_d;
   logic             z_q, z_d;
   logic             done_q, done_d;

   logic [OPC_W-1:0] op_code_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_cy_s;
   logic             alu_zero_s;
   logic             wr_a_s;
   logic             wr_cy_s;
   logic             wr_z_s;
   logic [WIDTH:0]   mul_sum_s;

   // Opcodes beyond the defined range collapse onto a no-op code.
   assign op_code_s = (op >= OP_W'(NUM_OPS)) ? 4'hF : op[OPC_W-1:0];

   alu_comb #(.WIDTH(WIDTH)) u_alu (
      .op_i    (op_code_s),
      .a_i     (a_q),
      .r_i     (R),
      .cy_i    (cy_q),
      .res_o   (alu_res_s),
      .cy_o    (alu_cy_s),
      .zero_o  (alu_zero_s),
      .wr_a_o  (wr_a_s),
      .wr_cy_o (wr_cy_s),
      .wr_z_o  (wr_z_s)
   );

   // During MUL, A holds the remaining multiplier bits and shifts right into H.
   assign mul_sum_s = {1'b0, h_q} + (a_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

   // Next-state: handshake, single-cycle writeback and MUL iteration.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      h_d     = h_q;
      mcand_d = mcand_q;
      cy_d    = cy_q;
      z_d     = z_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (op_code_s == OP_MUL)) begin
               mcand_d = a_q;
               a_d     = R;
               h_d     = {WIDTH{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               state_d = MUL_RUN;
            end else if (start) begin
               a_d    = wr_a_s  ? alu_res_s  : a_q;
               cy_d   = wr_cy_s ? alu_cy_s   : cy_q;
               z_d    = wr_z_s  ? alu_zero_s : z_q;
               done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         MUL_RUN: begin
            h_d   = mul_sum_s[WIDTH:1];
            a_d   = {mul_sum_s[0], a_q[WIDTH-1:1]};
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = IDLE;
               cy_d    = 1'b0;
               z_d     = ({h_d, a_d} == {(2*WIDTH){1'b0}});
               done_d  = 1'b1;
            end else begin
               state_d = MUL_RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset that also aborts a MUL in flight.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         h_q     <= {WIDTH{1'b0}};
         mcand_q <= {WIDTH{1'b0}};
         cy_q    <= 1'b0;
         z_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         h_q     <= h_d;
         mcand_q <= mcand_d;
         cy_q    <= cy_d;
         z_q     <= z_d;
         done_q  <= done_d;
      end
   end

   assign A    = a_q;
   assign H    = h_q;
   assign CY   = cy_q;
   assign Z    = z_q;
   assign busy = (state_q == MUL_RUN);
   assign done = done_q;

endmodule

// File: tb/tb_acc_alu_unit.sv
// Directed and randomized checks of acc_alu_unit against an arithmetic model.
module tb_acc_alu_unit;

   localparam int W    = 8;
   localparam int MASK = 255;

   logic         clk = 1'b0;
   logic         Reset = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] R = 8'd0;
   logic [W-1:0] A;
   logic [W-1:0] H;
   logic         CY;
   logic         Z;
   logic         busy;
   logic         done;

   int tests = 0;
   int fails = 0;
   int m_a = 0, m_h = 0, m_cy = 0, m_z = 0;

   acc_alu_unit #(.WIDTH(W), .OP_W(4)) dut (
      .clk(clk), .Reset(Reset), .start(start), .op(op), .R(R),
      .A(A), .H(H), .CY(CY), .Z(Z), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_A"},  {8'd0, A},  16'(m_a));
      check({tag, "_H"},  {8'd0, H},  16'(m_h));
      check({tag, "_CY"}, {15'd0, CY}, 16'(m_cy));
      check({tag, "_Z"},  {15'd0, Z},  16'(m_z));
   endtask

   // Reference: each op's effect written as plain integer arithmetic.
   task automatic model_step(input int o, input int r);
      int t;
      case (o)
         0: m_a = r;
         1: begin t = m_a + r;        m_cy = t >> 8; m_a = t & MASK; end
         2: begin t = m_a + r + m_cy; m_cy = t >> 8; m_a = t & MASK; end
         3: begin t = m_a - r;        m_cy = (t < 0); m_a = t & MASK; end
         4: begin t = m_a - r - m_cy; m_cy = (t < 0); m_a = t & MASK; end
         5: m_a = m_a & r;
         6: m_a = m_a | r;
         7: m_a = m_a ^ r;
         8: begin t = m_a * 2 + m_cy;   m_cy = t >> 8; m_a = t & MASK; end
         9: begin t = m_cy * 256 + m_a; m_cy = t & 1;  m_a = t >> 1; end
         default: ;
      endcase
      if (o <= 9) m_z = (m_a == 0);
      if (o == 10) begin
         t = m_a - r; m_cy = (t < 0); m_z = ((t & MASK) == 0);
      end
      if (o == 11) begin
         t = m_a * r; m_h = t >> 8; m_a = t & MASK; m_cy = 0; m_z = (t == 0);
      end
   endtask

   task automatic model_reset();
      m_a = 0; m_h = 0; m_cy = 0; m_z = 0;
   endtask

   // One accepted op; for MUL, optionally pokes start while busy.
   task automatic run_op(input int o, input int r, input bit inject);
      int n;
      @(negedge clk);
      op = 4'(o); R = 8'(r); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_step(o, r);
      if (o == 11) begin
         n = 0;
         while (busy === 1'b1 && n < 40) begin
            check("mul_no_done_while_busy", {15'd0, done}, 16'd0);
            start = inject; op = 4'd1; R = 8'h01;
            n++;
            @(negedge clk);
         end
         start = 1'b0;
         check("mul_busy_cycles", 16'(n), 16'(W));
      end else begin
         check("single_busy", {15'd0, busy}, 16'd0);
      end
      check("done_pulse", {15'd0, done}, 16'd1);
      check_state($sformatf("op%0d", o));
   endtask

   initial begin
      // 1: reset with start asserted, then release
      start = 1'b1; op = 4'd0; R = 8'h55;
      repeat (2) @(negedge clk);
      Reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check_state("reset");
      check("reset_busy", {15'd0, busy}, 16'd0);
      check("reset_done", {15'd0, done}, 16'd0);

      // 2: back-to-back LOAD 8, ADD 4
      op = 4'd0; R = 8'h08; start = 1'b1;
      @(negedge clk);
      model_step(0, 8);
      check("b2b_done1", {15'd0, done}, 16'd1);
      op = 4'd1; R = 8'h04;
      @(negedge clk);
      start = 1'b0;
      model_step(1, 4);
      check("b2b_done2", {15'd0, done}, 16'd1);
      check("b2b_A", {8'd0, A}, 16'h000C);
      check_state("b2b");
      @(negedge clk);
      check("done_falls", {15'd0, done}, 16'd0);
      run_op(3, 8'h10, 1'b0);
      check("sub_A", {8'd0, A}, 16'h00FC);
      check("sub_CY", {15'd0, CY}, 16'd1);

      // 3: carry chain and rotate
      run_op(0, 8'hFF, 1'b0);
      run_op(1, 8'h01, 1'b0);
      check("wrap_Z", {15'd0, Z}, 16'd1);
      run_op(2, 8'h00, 1'b0);
      check("adc_A", {8'd0, A}, 16'h0001);
      run_op(0, 8'h81, 1'b0);
      run_op(8, 8'h00, 1'b0);
      check("shl_A", {8'd0, A}, 16'h0002);
      check("shl_CY", {15'd0, CY}, 16'd1);

      // 4: 0xFF * 0xFF with ignored start while busy
      run_op(0, 8'hFF, 1'b0);
      run_op(11, 8'hFF, 1'b1);
      check("mul_HA", {H, A}, 16'hFE01);
      @(negedge clk);
      check("no_extra_done", {15'd0, done}, 16'd0);
      check_state("after_ignored");

      // 5: zero product and CMP equal
      run_op(0, 8'h37, 1'b0);
      run_op(11, 8'h00, 1'b0);
      check("mul0_Z", {15'd0, Z}, 16'd1);
      run_op(0, 8'h37, 1'b0);
      run_op(10, 8'h37, 1'b0);
      check("cmp_A", {8'd0, A}, 16'h0037);

      // 6: reset during MUL iteration 4
      @(negedge clk);
      op = 4'd11; R = 8'h5A; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      model_reset();
      check_state("mul_abort");
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_done", {15'd0, done}, 16'd0);
      @(negedge clk);
      check("abort_no_late_done", {15'd0, done}, 16'd0);
      run_op(0, 8'h05, 1'b0);

      // Randomized ops including undefined opcodes
      for (int i = 0; i < 150; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/acc_alu_unit.md
Name: acc_alu_unit

Overview:
Parametrised accumulator datapath that replaces the fixed 8-bit ALU + accumulator + carry-register trio. It fuses the ALU, accumulator A, high-word register H, carry flag CY and zero flag Z behind a start/busy/done handshake. It adds carry-chained ops and a multi-cycle shift-add unsigned multiply. It sits between the instruction decoder (opcode, operand R) and the register file / flag consumers of the uProcessor.

Parameters:
WIDTH, 8, data width of A, H and R (>= 2)
OP_W, 4, opcode width

Ports:
clk  input  1  single system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request to execute op on R; accepted only when busy=0
op  input  OP_W  opcode, sampled at accept edge
R  input  WIDTH  second operand, sampled at accept edge
A  output  WIDTH  accumulator (first operand and result)
H  output  WIDTH  high word of MUL result
CY  output  1  carry/borrow flag
Z  output  1  zero flag
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: result/flags valid

Behaviour:
- Reset, sampled on a clk edge: A=0, H=0, CY=0, Z=0, busy=0, done=0, sequencer idle. Reset has priority over everything, including a MUL in flight: it aborts it with no done pulse.
- Accept: start=1 and busy=0 at edge k. start while busy=1 is ignored, not queued.
- Single-cycle ops: A/CY/Z are written at edge k. done=1 for exactly the cycle after edge k. busy stays 0. Back-to-back starts on consecutive cycles are legal and produce consecutive done pulses.
- Opcodes and their effect:
  - 0 LOAD: A=R. CY unchanged.
  - 1 ADD: {CY,A}=A+R.
  - 2 ADC: {CY,A}=A+R+CY.
  - 3 SUB: A=A-R. CY=1 iff A<R (borrow).
  - 4 SBC: A=A-R-CY. CY=borrow.
  - 5 AND, 6 OR, 7 XOR: bitwise. CY unchanged.
  - 8 SHL: {CY,A}={A,CY}, rotate left through carry.
  - 9 SHR: {A,CY}={CY,A}, rotate right through carry.
  - 10 CMP: SUB flags only. A unchanged.
  - 11 MUL: see below.
  - 12-15: no-op, done pulse, state unchanged.
- Z: set to (result==0) on every op that writes A, and on CMP from the difference. No-op leaves Z unchanged.
- All arithmetic is unsigned, modulo 2^WIDTH, with carry out of bit WIDTH-1.
- MUL:
  - At accept edge k: latch multiplicand=A and multiplier=R, clear H, busy=1.
  - Edges k+1..k+WIDTH: one shift-add iteration each, with an internal iteration counter.
  - At edge k+WIDTH: {H,A}=A*R (2*WIDTH bits), CY=0, Z=({H,A}==0), busy=0. done=1 in the following cycle.
  - A and H show intermediate values while busy=1; consumers must wait for done.
- Sequencer states:
  - IDLE -> MUL_RUN on an accepted MUL.
  - MUL_RUN -> IDLE when the counter reaches WIDTH-1.
  - Any state -> IDLE on Reset.
- done is never asserted while busy=1.

Decomposition:
- Package acc_alu_pkg holds:
  - opcode enum (OP_LOAD..OP_MUL), sized OP_W;
  - sequencer state enum {IDLE, MUL_RUN};
  - localparam NUM_OPS=12.
- Sub-module alu_comb (combinational, parametrised WIDTH) computes result, carry-out and zero for single-cycle ops and CMP.
- The top level holds the registers, the MUL shift-add sequencer and the handshake.

Test Plan:
1. Reset held 2 cycles, then released -> A=0, H=0, CY=0, Z=0, busy=0, done=0. Start asserted during Reset -> ignored.
2. LOAD R=8, then ADD R=4 on the next cycle -> A=0x0C, CY=0, Z=0, two consecutive done pulses. Then SUB R=0x10 -> A=0xFC, CY=1, Z=0.
3. LOAD 0xFF, ADD 0x01 -> A=0x00, CY=1, Z=1. Then ADC R=0 -> A=0x01, CY=0. Then LOAD 0x81, CY=0, SHL -> A=0x02, CY=1.
4. LOAD 0xFF, MUL R=0xFF -> busy high 8 cycles, done in cycle 9 after accept, {H,A}=0xFE01, CY=0, Z=0. Start ADD while busy -> ignored, no extra done.
5. MUL R=0x00 with A=0x37 -> {H,A}=0x0000, Z=1. CMP R=0x37 with A=0x37 -> Z=1, CY=0, A unchanged.
6. Reset asserted at iteration 4 of a MUL -> next cycle all outputs 0, busy=0, no done. A following LOAD 0x05 works normally (done pulse, A=0x05).
